// File: rtl/dm_access_unit.sv
// Load/store execution unit between the datapath and a word-wide handshaked data memory bus.
// Handles byte/halfword lane extraction, sign/zero extension, SB/SH read-modify-write and timeouts.
module dm_access_unit #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  DMRe,
    input  logic [1:0]  DMWr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic [2:0]  state_dbg
);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [2:0] LD_LB  = 3'd1;
    localparam logic [2:0] LD_LBU = 3'd2;
    localparam logic [2:0] LD_LH  = 3'd3;
    localparam logic [2:0] LD_LHU = 3'd4;
    localparam logic [2:0] LD_LW  = 3'd5;
    localparam logic [1:0] ST_SB  = 2'd1;
    localparam logic [1:0] ST_SH  = 2'd2;
    localparam logic [1:0] ST_SW  = 2'd3;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD     = 3'd1,
        RMW_RD = 3'd2,
        RMW_WR = 3'd3,
        WR     = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  ld_q, ld_d;
    logic [1:0]  st_q, st_d;
    logic [1:0]  off_q, off_d;
    logic [15:0] sdata_q, sdata_d;
    logic        err_q, err_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] maddr_q, maddr_d;
    logic [31:0] mwdata_q, mwdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic        cmd, misalign, acked, timeout_hit;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_val, merge_val;

    // Bus handshake: mem_req is held, with mem_addr/mem_we/mem_wdata stable, until a
    // cycle in which mem_ack is high; that cycle completes the transfer.
    always_comb begin
        cmd         = ((DMRe >= LD_LB) && (DMRe <= LD_LW)) || (DMWr != 2'd0);
        misalign    = (((DMRe == LD_LH) || (DMRe == LD_LHU) || (DMWr == ST_SH)) && addr[0]) ||
                      (((DMRe == LD_LW) || (DMWr == ST_SW)) && (addr[1:0] != 2'b00));
        acked       = req_q && mem_ack;
        timeout_hit = (TIMEOUT != 0) && req_q && !mem_ack && (cnt_q == CW'(TIMEOUT - 1));

        case (off_q)
            2'd0:    byte_sel = mem_rdata[7:0];
            2'd1:    byte_sel = mem_rdata[15:8];
            2'd2:    byte_sel = mem_rdata[23:16];
            default: byte_sel = mem_rdata[31:24];
        endcase
        half_sel = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

        case (ld_q)
            LD_LB:   load_val = {{24{byte_sel[7]}}, byte_sel};
            LD_LBU:  load_val = {24'd0, byte_sel};
            LD_LH:   load_val = {{16{half_sel[15]}}, half_sel};
            LD_LHU:  load_val = {16'd0, half_sel};
            default: load_val = mem_rdata;
        endcase

        merge_val = mem_rdata;
        case (st_q)
            ST_SB: begin
                case (off_q)
                    2'd0:    merge_val[7:0]   = sdata_q[7:0];
                    2'd1:    merge_val[15:8]  = sdata_q[7:0];
                    2'd2:    merge_val[23:16] = sdata_q[7:0];
                    default: merge_val[31:24] = sdata_q[7:0];
                endcase
            end
            default: begin
                if (off_q[1]) merge_val[31:16] = sdata_q;
                else          merge_val[15:0]  = sdata_q;
            end
        endcase
    end

    always_comb begin
        state_d  = state_q;
        ld_d     = ld_q;
        st_d     = st_q;
        off_d    = off_q;
        sdata_d  = sdata_q;
        err_d    = err_q;
        req_d    = req_q;
        we_d     = we_q;
        maddr_d  = maddr_q;
        mwdata_d = mwdata_q;
        rdata_d  = rdata_q;
        cnt_d    = cnt_q;

        case (state_q)
            IDLE: begin
                err_d = 1'b0;
                cnt_d = '0;
                if (cmd) begin
                    ld_d    = DMRe;
                    st_d    = DMWr;
                    off_d   = addr[1:0];
                    sdata_d = wdata[15:0];
                    maddr_d = {addr[31:2], 2'b00};
                    if ((DMRe != 3'd0) && (DMWr != 2'd0)) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else if (misalign) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else if (DMRe != 3'd0) begin
                        req_d   = 1'b1;
                        we_d    = 1'b0;
                        state_d = RD;
                    end else if (DMWr == ST_SW) begin
                        req_d    = 1'b1;
                        we_d     = 1'b1;
                        mwdata_d = wdata;
                        state_d  = WR;
                    end else begin
                        req_d   = 1'b1;
                        we_d    = 1'b0;
                        state_d = RMW_RD;
                    end
                end
            end
            RD, RMW_RD, RMW_WR, WR: begin
                if (acked) begin
                    cnt_d = '0;
                    req_d = 1'b0;
                    if (state_q == RD) begin
                        rdata_d = load_val;
                        state_d = DONE;
                    end else if (state_q == RMW_RD) begin
                        mwdata_d = merge_val;
                        we_d     = 1'b1;
                        state_d  = RMW_WR;
                    end else begin
                        we_d    = 1'b0;
                        state_d = DONE;
                    end
                end else if (timeout_hit) begin
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    err_d   = 1'b1;
                    state_d = DONE;
                end else if (req_q) begin
                    cnt_d = cnt_q + CW'(1);
                end else begin
                    // RMW write phase: request rises one idle cycle after the read completes
                    req_d = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            ld_q     <= '0;
            st_q     <= '0;
            off_q    <= '0;
            sdata_q  <= '0;
            err_q    <= 1'b0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            maddr_q  <= '0;
            mwdata_q <= '0;
            rdata_q  <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            ld_q     <= ld_d;
            st_q     <= st_d;
            off_q    <= off_d;
            sdata_q  <= sdata_d;
            err_q    <= err_d;
            req_q    <= req_d;
            we_q     <= we_d;
            maddr_q  <= maddr_d;
            mwdata_q <= mwdata_d;
            rdata_q  <= rdata_d;
            cnt_q    <= cnt_d;
        end
    end

    assign busy      = ((state_q != IDLE) && (state_q != DONE)) || ((state_q == IDLE) && cmd);
    assign done      = (state_q == DONE);
    assign err       = (state_q == DONE) && err_q;
    assign rdata     = rdata_q;
    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = maddr_q;
    assign mem_wdata = mwdata_q;
    assign state_dbg = state_q;

endmodule
